regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-side front end of the RV32I integer register file.
//  - Collects results from the ALU and the load/store unit (LSU) through valid/ready handshakes.
//  - Sign- or zero-extends load data.
//  - Arbitrates both sources onto the register file's single write port (WE/WA/WD).
//  - Buffers each source in a small FIFO so one source can stall without blocking the other.
// PARAMETERS
//  XLEN        32  data width
//  DEPTH       2   entries per source FIFO (power of 2, >=2)
//  STARVE_MAX  4   consecutive ALU losses before ALU is forced to win
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, asynchronous, active-low
//  alu_valid    in   1     ALU result valid
//  alu_ready    out  1     ALU FIFO not full
//  alu_rd       in   5     ALU destination register
//  alu_data     in   XLEN  ALU result
//  lsu_valid    in   1     load result valid
//  lsu_ready    out  1     LSU FIFO not full
//  lsu_rd       in   5     load destination register
//  lsu_data     in   XLEN  raw aligned memory word
//  lsu_funct3   in   3     load funct3 (LB/LH/LW/LBU/LHU)
//  lsu_addr_lo  in   2     effective address bits [1:0]
//  rf_we        out  1     register-file write enable
//  rf_wa        out  5     register-file write address
//  rf_wd        out  XLEN  register-file write data
//  busy         out  1     any FIFO non-empty or rf_we high
// BEHAVIOUR
//  Reset
//  - While rst_n=0: FIFOs empty; rf_we=0, rf_wa=0, rf_wd=0; starve count=0; alu_ready=lsu_ready=1; busy=0.
//  - Reset mid-operation discards all buffered results immediately.
//  Handshake
//  - Transfer occurs on a rising edge with valid&&ready.
//  - ready = !full, purely from FIFO occupancy. A full FIFO does not accept a push even if it pops in the same cycle.
//  - Payload may change freely when ready=0.
//  Load extension (applied at enqueue; FIFO stores the extended value)
//  - 000 LB:  byte lsu_data[8*addr_lo +: 8], sign-extended.
//  - 100 LBU: same byte, zero-extended.
//  - 001 LH:  half lsu_data[16*addr_lo[1] +: 16], sign-extended; addr_lo[0] ignored.
//  - 101 LHU: same half, zero-extended.
//  - 010 LW and all other codes: lsu_data unchanged.
//  Arbitration (combinational on FIFO heads, one pop per cycle)
//  - Only one FIFO non-empty: that source wins.
//  - Both non-empty: LSU wins unless starve count == STARVE_MAX, in which case ALU wins.
//  - Starve count: +1 when ALU is non-empty and loses; cleared when ALU wins or ALU FIFO is empty; saturates at STARVE_MAX.
//  Write port (registered)
//  - On the edge where a winner is popped: rf_we <= (rd!=0), rf_wa <= rd, rf_wd <= data.
//  - With no winner: rf_we <= 0; rf_wa and rf_wd hold their values.
//  - rd==0 entries are popped but never written; x0 stays zero.
//  Ordering and latency
//  - Per-source order is preserved. Cross-source order is not guaranteed; RAW/WAW hazards are resolved upstream.
//  - Latency: accepted at edge E0 into an empty, uncontended FIFO -> rf_we high for exactly the cycle after edge E0+1.
//  - Sustained throughput: one write per cycle total.
// TESTING
//  T1 Reset mid-operation
//   - Stimulus: fill both FIFOs, then pulse rst_n low between edges.
//   - Required: rf_we=0 asynchronously; after release, alu_ready=lsu_ready=1, busy=0, no stale writes.
//  T2 Single ALU result
//   - Stimulus: alu_rd=5, alu_data=0x12345678.
//   - Required: rf_we=1, rf_wa=5, rf_wd=0x12345678 for one cycle, two edges after acceptance.
//  T3 x0 destination
//   - Stimulus: alu_rd=0, alu_data=0xFFFFFFFF.
//   - Required: entry popped, rf_we stays 0, busy returns to 0.
//  T4 Load extension, lsu_data=0x80FF7F01
//   - LB  addr 3 -> 0xFFFFFF80
//   - LBU addr 1 -> 0x0000007F
//   - LH  addr 2 -> 0xFFFF80FF
//   - LHU addr 0 -> 0x00007F01
//   - LW         -> 0x80FF7F01
//  T5 Fairness
//   - Stimulus: both sources stream back-to-back, STARVE_MAX=4.
//   - Required: write pattern repeats 4 LSU then 1 ALU; each source's rd sequence stays in order.
//  T6 Backpressure
//   - Stimulus: LSU streams continuously while the ALU pushes 3 results.
//   - Required: alu_ready drops to 0 after 2 accepted; third accepted only after an ALU pop; no data lost or duplicated.

Source files
------------

// File: rtl/regfile_writeback.sv
// Register-file write front end: buffers ALU and load results, extends loads,
// and arbitrates both sources onto the single register-file write port.
module regfile_writeback_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module regfile_writeback #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [2:0]      lsu_funct3,
    input  logic [1:0]      lsu_addr_lo,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            busy
);
    localparam int W  = 5 + XLEN;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] lsu_ext;

    assign ld_byte = lsu_data[{lsu_addr_lo, 3'b000} +: 8];
    assign ld_half = lsu_data[{lsu_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        lsu_ext = lsu_data;
        unique case (lsu_funct3)
            3'b000:  lsu_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  lsu_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  lsu_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  lsu_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: lsu_ext = lsu_data;
        endcase
    end

    logic [W-1:0] alu_head;
    logic [W-1:0] lsu_head;
    logic         alu_full;
    logic         alu_empty;
    logic         lsu_full;
    logic         lsu_empty;
    logic         pick_alu;
    logic         pick_lsu;
    logic [SW-1:0] starve;

    regfile_writeback_fifo #(.W(W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (alu_valid),
        .din   ({alu_rd, alu_data}),
        .pop   (pick_alu),
        .dout  (alu_head),
        .full  (alu_full),
        .empty (alu_empty)
    );

    regfile_writeback_fifo #(.W(W), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_valid),
        .din   ({lsu_rd, lsu_ext}),
        .pop   (pick_lsu),
        .dout  (lsu_head),
        .full  (lsu_full),
        .empty (lsu_empty)
    );

    assign alu_ready = !alu_full;
    assign lsu_ready = !lsu_full;

    // LSU has priority; a starved ALU is forced through once.
    assign pick_alu = !alu_empty && (lsu_empty || starve == SMAX);
    assign pick_lsu = !lsu_empty && !pick_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (alu_empty || pick_alu) begin
            starve <= '0;
        end else if (starve != SMAX) begin
            starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (pick_alu) begin
            rf_we <= (alu_head[W-1 -: 5] != 5'd0);
            rf_wa <= alu_head[W-1 -: 5];
            rf_wd <= alu_head[XLEN-1:0];
        end else if (pick_lsu) begin
            rf_we <= (lsu_head[W-1 -: 5] != 5'd0);
            rf_wa <= lsu_head[W-1 -: 5];
            rf_wd <= lsu_head[XLEN-1:0];
        end else begin
            rf_we <= 1'b0;
        end
    end

    assign busy = !alu_empty || !lsu_empty || rf_we;
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: per-source expected queues,
// independent write monitor, directed and random traffic.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic [2:0]  lsu_funct3 = '0;
    logic [1:0]  lsu_addr_lo = '0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        busy;

    always #5 clk = ~clk;

    regfile_writeback #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_funct3  (lsu_funct3),
        .lsu_addr_lo (lsu_addr_lo),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .busy        (busy)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t alu_q[$];
    ent_t lsu_q[$];
    byte  src_log[$];
    int   n_pass = 0;
    int   n_total = 0;
    ent_t mon_got;
    ent_t head_a;
    ent_t head_l;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference load extension from plain shifts and masks.
    function automatic logic [31:0] ref_ext(input logic [31:0] d,
                                            input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (d >> (8 * lo)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (d >> (16 * (lo / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    // Monitor: each write must match the head of one source's queue.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            mon_got.rd   = rf_wa;
            mon_got.data = rf_wd;
            head_a = (alu_q.size() > 0) ? alu_q[0] : '0;
            head_l = (lsu_q.size() > 0) ? lsu_q[0] : '0;
            n_total++;
            if (lsu_q.size() > 0 && head_l == mon_got) begin
                void'(lsu_q.pop_front());
                src_log.push_back("L");
                n_pass++;
            end else if (alu_q.size() > 0 && head_a == mon_got) begin
                void'(alu_q.pop_front());
                src_log.push_back("A");
                n_pass++;
            end else begin
                $display("FAIL write: got rd=%0d data=%h, alu head %h lsu head %h",
                         rf_wa, rf_wd, head_a, head_l);
            end
        end
    end

    task automatic alu_send(input logic [4:0] rd, input logic [31:0] d,
                            output int waited);
        int n = 0;
        bit acc = 1'b0;
        alu_valid = 1'b1;
        alu_rd = rd;
        alu_data = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = alu_ready;
            @(posedge clk);
            #1;
            if (!acc) n++;
        end
        alu_valid = 1'b0;
        if (acc) begin
            if (rd != 5'd0) alu_q.push_back('{rd: rd, data: d});
        end else begin
            chk("alu_accept_timeout", 32'd0, 32'd1);
        end
        waited = n;
    endtask

    task automatic lsu_send(input logic [4:0] rd, input logic [31:0] d,
                            input logic [2:0] f3, input logic [1:0] lo,
                            output int waited);
        int n = 0;
        bit acc = 1'b0;
        lsu_valid = 1'b1;
        lsu_rd = rd;
        lsu_data = d;
        lsu_funct3 = f3;
        lsu_addr_lo = lo;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = lsu_ready;
            @(posedge clk);
            #1;
            if (!acc) n++;
        end
        lsu_valid = 1'b0;
        if (acc) begin
            if (rd != 5'd0) lsu_q.push_back('{rd: rd, data: ref_ext(d, f3, lo)});
        end else begin
            chk("lsu_accept_timeout", 32'd0, 32'd1);
        end
        waited = n;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 400 && !(alu_q.size() == 0 && lsu_q.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 400), 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  t4_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  t4_lo  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] t4_exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int mism;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", 32'(rf_we), 32'd0);
        chk("reset_wa", 32'(rf_wa), 32'd0);
        chk("reset_wd", rf_wd, 32'd0);
        chk("reset_alu_ready", 32'(alu_ready), 32'd1);
        chk("reset_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU result: write visible after the second edge only.
        alu_send(5'd5, 32'h1234_5678, w);
        chk("t2_we_early", 32'(rf_we), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_we", 32'(rf_we), 32'd1);
        chk("t2_wa", 32'(rf_wa), 32'd5);
        chk("t2_wd", rf_wd, 32'h1234_5678);
        @(posedge clk);
        #1;
        chk("t2_we_one_cycle", 32'(rf_we), 32'd0);
        drain("t2_drain");

        // x0 destination is consumed but never written.
        alu_send(5'd0, 32'hFFFF_FFFF, w);
        chk("t3_busy_held", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_we", 32'(rf_we), 32'd0);
        chk("t3_busy_clear", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            lsu_send(5'(i + 1), 32'h80FF_7F01, t4_f3[i], t4_lo[i], w);
            @(posedge clk);
            #1;
            chk("t4_we", 32'(rf_we), 32'd1);
            chk("t4_ext", rf_wd, t4_exp[i]);
        end
        drain("t4_drain");

        fork
            begin
                int wa;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    alu_send(5'($urandom_range(0, 31)), $urandom, wa);
                end
            end
            begin
                int wl;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    lsu_send(5'($urandom_range(0, 31)), $urandom,
                             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), wl);
                end
            end
        join
        drain("rand_drain");

        // Fairness: both saturated, expect 4 LSU then 1 ALU.
        src_log.delete();
        fork
            begin
                int wa;
                for (int i = 0; i < 8; i++) alu_send(5'(i + 1), $urandom, wa);
            end
            begin
                int wl;
                for (int i = 0; i < 40; i++)
                    lsu_send(5'((i % 31) + 1), $urandom, 3'd2, 2'd0, wl);
            end
        join
        drain("t5_drain");
        chk("t5_writes", 32'(src_log.size()), 32'd48);
        mism = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= src_log.size()) mism++;
            else if (src_log[i] != ((i % 5 == 4) ? "A" : "L")) mism++;
        end
        chk("t5_pattern", 32'(mism), 32'd0);

        // Backpressure: third ALU push must wait for an ALU pop.
        fork
            begin
                int wl;
                for (int i = 0; i < 20; i++)
                    lsu_send(5'((i % 31) + 1), $urandom, 3'd2, 2'd0, wl);
            end
            begin
                int wa;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                alu_send(5'd10, $urandom, wa);
                alu_send(5'd11, $urandom, wa);
                chk("t6_alu_ready_low", 32'(alu_ready), 32'd0);
                alu_send(5'd12, $urandom, wa);
                chk("t6_third_stalled", 32'(wa > 0), 32'd1);
            end
        join
        drain("t6_drain");

        // Reset mid-operation discards buffered results.
        fork
            begin
                int wa;
                alu_send(5'd20, $urandom, wa);
                alu_send(5'd21, $urandom, wa);
            end
            begin
                int wl;
                lsu_send(5'd22, $urandom, 3'd2, 2'd0, wl);
                lsu_send(5'd23, $urandom, 3'd2, 2'd0, wl);
            end
        join
        chk("t1_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_we_async", 32'(rf_we), 32'd0);
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        alu_q.delete();
        lsu_q.delete();
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("t1_idle_after", 32'(busy), 32'd0);
        alu_send(5'd7, 32'hCAFE_0007, w);
        drain("t1_resume_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
